// File: rtl/clk_digit_scan.sv
// Multiplexed display scanner: steps a digit index at a programmable rate and
// emits the code of each position from a per-frame snapshot of time or alarm fields.
module clk_digit_scan #(
  parameter int         NUM_DIGITS   = 8,
  parameter int         SCAN_DIV     = 1000,
  parameter int         BLINK_FRAMES = 64,
  parameter bit         SHOW_SEP     = 1'b1,
  parameter logic [3:0] SEP_CODE     = 4'd11,
  parameter logic [3:0] BLANK_CODE   = 4'd10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_sel,
  input  logic [6:0]            hour,
  input  logic [6:0]            minute,
  input  logic [6:0]            second,
  input  logic [6:0]            alm_hour,
  input  logic [6:0]            alm_minute,
  input  logic [6:0]            alm_second,
  input  logic [1:0]            edit_field,
  output logic [3:0]            num,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start
);

  localparam int PRESC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int KIND_BLANK = 0;
  localparam int KIND_SEP   = 1;
  localparam int KIND_DIGIT = 2;

  function automatic int pos_kind(input int p);
    if (SHOW_SEP) begin
      if (p > 7) return KIND_BLANK;
      if (p == 2 || p == 5) return KIND_SEP;
      return KIND_DIGIT;
    end
    if (p > 5) return KIND_BLANK;
    return KIND_DIGIT;
  endfunction

  // Field number of a digit position: 1 hours, 2 minutes, 3 seconds.
  function automatic int pos_field(input int p);
    if (SHOW_SEP) return (p < 2) ? 1 : ((p < 5) ? 2 : 3);
    return (p / 2) + 1;
  endfunction

  function automatic bit pos_tens(input int p);
    if (SHOW_SEP) return (p == 0 || p == 3 || p == 6);
    return (p % 2) == 0;
  endfunction

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  load_pending_q;
  logic                  snap_src_q, snap_src_d;
  logic [1:0]            snap_edit_q, snap_edit_d;
  logic [6:0]            snap_time_q [3];
  logic [6:0]            snap_time_d [3];
  logic [6:0]            snap_alm_q [3];
  logic [6:0]            snap_alm_d [3];
  logic [6:0]            live_time [3];
  logic [6:0]            live_alm [3];
  logic [3:0]            num_q, num_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_start_q, frame_start_d;
  logic                  tick, wrap, load;
  logic [1:0]            edit_eff;
  logic [6:0]            fld_val [3];
  logic [3:0]            fld_tens [3];
  logic [3:0]            fld_ones [3];
  logic [3:0]            pos_code [NUM_DIGITS];

  assign live_time[0] = hour;
  assign live_time[1] = minute;
  assign live_time[2] = second;
  assign live_alm[0]  = alm_hour;
  assign live_alm[1]  = alm_minute;
  assign live_alm[2]  = alm_second;

  always_comb begin
    tick          = (presc_q == PRESC_W'(SCAN_DIV - 1));
    wrap          = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    load          = wrap || load_pending_q;
    presc_d       = tick ? '0 : presc_q + 1'b1;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      idx_d = '0;
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else if (tick) begin
      idx_d = idx_q + 1'b1;
    end
    snap_src_d  = load ? src_sel : snap_src_q;
    snap_edit_d = load ? edit_field : snap_edit_q;
  end

  // The first frame after reset reads the live inputs so digit 0 already shows the fresh snapshot.
  assign edit_eff = load_pending_q ? edit_field : snap_edit_q;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_field
      assign snap_time_d[gi] = load ? live_time[gi] : snap_time_q[gi];
      assign snap_alm_d[gi]  = load ? live_alm[gi] : snap_alm_q[gi];
      assign fld_val[gi]  = load_pending_q ? (src_sel ? live_alm[gi] : live_time[gi])
                                           : (snap_src_q ? snap_alm_q[gi] : snap_time_q[gi]);
      assign fld_tens[gi] = (fld_val[gi] > 7'd99) ? 4'd9 : 4'(fld_val[gi] / 7'd10);
      assign fld_ones[gi] = (fld_val[gi] > 7'd99) ? 4'd9 : 4'(fld_val[gi] % 7'd10);
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
      if (pos_kind(gi) == KIND_BLANK) begin : g_blank
        assign pos_code[gi] = BLANK_CODE;
      end else if (pos_kind(gi) == KIND_SEP) begin : g_sep
        assign pos_code[gi] = SEP_CODE;
      end else begin : g_digit
        localparam int F = pos_field(gi) - 1;
        localparam bit T = pos_tens(gi);
        assign pos_code[gi] = (blink_phase_q && (edit_eff == 2'(F + 1))) ? BLANK_CODE
                            : (T ? fld_tens[F] : fld_ones[F]);
      end
      assign an_d[gi] = (idx_q != IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    num_d         = pos_code[idx_q];
    frame_start_d = (idx_q == '0) && (presc_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q        <= '0;
      idx_q          <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      load_pending_q <= 1'b1;
      snap_src_q     <= 1'b0;
      snap_edit_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        snap_time_q[i] <= '0;
        snap_alm_q[i]  <= '0;
      end
      num_q          <= BLANK_CODE;
      an_q           <= '1;
      frame_start_q  <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      load_pending_q <= 1'b0;
      snap_src_q     <= snap_src_d;
      snap_edit_q    <= snap_edit_d;
      for (int i = 0; i < 3; i++) begin
        snap_time_q[i] <= snap_time_d[i];
        snap_alm_q[i]  <= snap_alm_d[i];
      end
      num_q          <= num_d;
      an_q           <= an_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign num         = num_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_clk_digit_scan.sv
// Bench for clk_digit_scan: two configurations driven by shared directed and random
// stimulus, checked every cycle against a frame-level reference model.
module tb_clk_digit_scan;

  localparam int ND = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          src_sel;
  logic [6:0]    hour, minute, second, alm_hour, alm_minute, alm_second;
  logic [1:0]    edit_field;
  logic [3:0]    num_a, num_b;
  logic [ND-1:0] an_a, an_b;
  logic          fs_a, fs_b;

  clk_digit_scan #(.NUM_DIGITS(ND), .SCAN_DIV(4), .BLINK_FRAMES(2), .SHOW_SEP(1'b1)) dut_sep (
    .clk(clk), .rst_n(rst_n), .src_sel(src_sel),
    .hour(hour), .minute(minute), .second(second),
    .alm_hour(alm_hour), .alm_minute(alm_minute), .alm_second(alm_second),
    .edit_field(edit_field), .num(num_a), .an(an_a), .frame_start(fs_a)
  );

  clk_digit_scan #(.NUM_DIGITS(ND), .SCAN_DIV(1), .BLINK_FRAMES(3), .SHOW_SEP(1'b0)) dut_nosep (
    .clk(clk), .rst_n(rst_n), .src_sel(src_sel),
    .hour(hour), .minute(minute), .second(second),
    .alm_hour(alm_hour), .alm_minute(alm_minute), .alm_second(alm_second),
    .edit_field(edit_field), .num(num_b), .an(an_b), .frame_start(fs_b)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state, one slot per instance.
  int div [2] = '{4, 1};
  int bfr [2] = '{2, 3};
  bit sep [2] = '{1'b1, 1'b0};
  int map_sep   [8] = '{1, 1, 0, 2, 2, 0, 3, 3};  // 0 separator, 1..3 field
  int map_nosep [8] = '{1, 1, 2, 2, 3, 3, -1, -1}; // -1 beyond layout
  int k [2];
  int s_h [2], s_m [2], s_s [2], s_edit [2];
  int exp_num [2], exp_fs [2];
  logic [ND-1:0] exp_an [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else pass_cnt++;
  endtask

  function automatic int exp_code(input bit sp, input int pos, input int h, input int m,
                                  input int s, input int edit, input int ph);
    int fld, prev, v;
    bit first;
    fld = sp ? map_sep[pos] : map_nosep[pos];
    if (fld < 0) return 10;
    if (fld == 0) return 11;
    if (ph == 1 && edit == fld) return 10;
    v = (fld == 1) ? h : ((fld == 2) ? m : s);
    if (v > 99) v = 99;
    first = 1'b1;
    if (pos > 0) begin
      prev  = sp ? map_sep[pos-1] : map_nosep[pos-1];
      first = (prev != fld);
    end
    return first ? v / 10 : v % 10;
  endfunction

  task automatic take_snap(input int u);
    s_h[u]    = src_sel ? int'(alm_hour)   : int'(hour);
    s_m[u]    = src_sel ? int'(alm_minute) : int'(minute);
    s_s[u]    = src_sel ? int'(alm_second) : int'(second);
    s_edit[u] = int'(edit_field);
  endtask

  // One clock: advance the model on the edge, then compare both instances.
  task automatic step();
    int pos, f, dn, ph;
    logic [ND-1:0] one;
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        k[u] = 0; exp_num[u] = 10; exp_an[u] = '1; exp_fs[u] = 0;
      end else begin
        k[u]++;
        dn = div[u] * ND;
        if (k[u] == 1) take_snap(u);
        pos = ((k[u] - 1) / div[u]) % ND;
        f   = (k[u] - 1) / dn;
        ph  = (f / bfr[u]) % 2;
        exp_num[u] = exp_code(sep[u], pos, s_h[u], s_m[u], s_s[u], s_edit[u], ph);
        one        = ND'(1) << pos;
        exp_an[u]  = ~one;
        exp_fs[u]  = ((k[u] - 1) % dn == 0) ? 1 : 0;
        if (k[u] % dn == 0) take_snap(u);
      end
    end
    #1;
    check("sep.num",   32'(num_a), 32'(exp_num[0]));
    check("sep.an",    32'(an_a),  32'(exp_an[0]));
    check("sep.fs",    32'(fs_a),  32'(exp_fs[0]));
    check("nosep.num", 32'(num_b), 32'(exp_num[1]));
    check("nosep.an",  32'(an_b),  32'(exp_an[1]));
    check("nosep.fs",  32'(fs_b),  32'(exp_fs[1]));
  endtask

  initial begin
    rst_n = 1'b0; src_sel = 1'b0; edit_field = 2'd0;
    hour = 7'd12; minute = 7'd34; second = 7'd56;
    alm_hour = 7'd0; alm_minute = 7'd0; alm_second = 7'd0;

    $display("phase reset+scan 12:34:56");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();

    $display("phase minute change while idx=1");
    minute = 7'd35;
    repeat (60) step();

    $display("phase alarm source 07:123:09");
    src_sel = 1'b1; alm_hour = 7'd7; alm_minute = 7'd123; alm_second = 7'd9;
    repeat (70) step();

    $display("phase blink on minutes");
    src_sel = 1'b0; edit_field = 2'd2;
    repeat (160) step();

    $display("phase reset at idx=5");
    for (int n = 0; n < 64 && (((k[0] - 1) / div[0]) % ND) != 5; n++) step();
    check("sep.reach_idx5", 32'(((k[0] - 1) / div[0]) % ND), 32'd5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; hour = 7'd23; minute = 7'd59; second = 7'd58; edit_field = 2'd1;
    repeat (80) step();

    $display("phase random stimulus");
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 7))
          0: hour       = 7'($urandom_range(0, 127));
          1: minute     = 7'($urandom_range(0, 127));
          2: second     = 7'($urandom_range(0, 127));
          3: alm_hour   = 7'($urandom_range(0, 127));
          4: alm_minute = 7'($urandom_range(0, 127));
          5: alm_second = 7'($urandom_range(0, 127));
          6: src_sel    = 1'($urandom_range(0, 1));
          default: edit_field = 2'($urandom_range(0, 3));
        endcase
      end
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
